// File: rtl/ram_mp_clr.sv
// ram_mp_clr: single write port with byte enables, NUM_RD registered read
// ports with valid strobes, selectable read/write collision behaviour and a
// built-in sweep that zeroes the whole array after reset or on request.
module ram_mp_clr #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 36,
  parameter int BYTE_WIDTH  = 9,
  parameter int NUM_RD      = 2,
  parameter int WRITE_FIRST = 0,
  parameter int CLR_ON_RST  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_i,
  output logic                           busy_o,
  input  logic                           we_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]          waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [NUM_RD-1:0]              re_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_RD-1:0]              rvalid_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [0:0] ST_RST   = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  // Lanes must tile the word exactly, otherwise byte enables would leave
  // stray bits that no lane owns.
  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_byte_width
      $error("ram_mp_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (NUM_RD < 1) begin : g_bad_num_rd
      $error("ram_mp_clr: NUM_RD must be at least 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] wr_merge;
  logic                  busy;

  assign busy   = (state == ST_CLEAR);
  assign busy_o = busy;

  // Clear sequencer: one address per cycle, back to idle after the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RST;
      cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (clr_i) begin
        state <= ST_CLEAR;
      end
    end else begin
      if (cnt == CNT_LAST) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Array update: the sweep owns the array while busy, user writes are dropped.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[cnt] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          mem[waddr_i][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Word as it will look after this cycle's write, used for write-first reads.
  always_comb begin
    wr_merge = mem[waddr_i];
    for (int i = 0; i < NB; i++) begin
      if (be_i[i]) begin
        wr_merge[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata_i[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] raddr;
      logic                  hit;
      logic [DATA_WIDTH-1:0] rd_word;
      logic [DATA_WIDTH-1:0] rdata_q;
      logic                  rvalid_q;

      assign raddr   = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit     = (WRITE_FIRST != 0) && we_i && (raddr == waddr_i);
      assign rd_word = hit ? wr_merge : mem[raddr];

      // Read output register: data holds between requests, valid pulses per read.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else if (busy) begin
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= re_i[k];
          if (re_i[k]) begin
            rdata_q <= rd_word;
          end
        end
      end

      assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
      assign rvalid_o[k]                         = rvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_mp_clr.sv
// tb_ram_mp_clr: scoreboard bench for ram_mp_clr. DUT a is read-first with
// clear-on-reset; DUT b is write-first without clear-on-reset.
module tb_ram_mp_clr;

  localparam int AW = 4;
  localparam int DW = 36;
  localparam int BW = 9;
  localparam int NR = 2;
  localparam int NBL = DW / BW;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              clr, we, busy;
  logic [NBL-1:0]    be;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NR-1:0]     re, rvalid;
  logic [NR*AW-1:0]  raddr;
  logic [NR*DW-1:0]  rdata;

  logic              b_clr, b_we, b_busy;
  logic [NBL-1:0]    b_be;
  logic [AW-1:0]     b_waddr;
  logic [DW-1:0]     b_wdata;
  logic [NR-1:0]     b_re, b_rvalid;
  logic [NR*AW-1:0]  b_raddr;
  logic [NR*DW-1:0]  b_rdata;

  typedef struct {
    string        tag;
    logic [35:0]  val;
  } sb_entry_t;

  sb_entry_t   exp_q[$];
  sb_entry_t   obs_q[$];
  logic [35:0] model_mem [DEPTH];
  logic [35:0] last_rd [NR];
  int          tests_run = 0;
  int          tests_failed = 0;

  ram_mp_clr #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .NUM_RD(NR),
    .WRITE_FIRST(0), .CLR_ON_RST(1)
  ) dut_a (
    .clk(clk), .rst(rst), .clr_i(clr), .busy_o(busy), .we_i(we), .be_i(be),
    .waddr_i(waddr), .wdata_i(wdata), .re_i(re), .raddr_i(raddr),
    .rdata_o(rdata), .rvalid_o(rvalid)
  );

  ram_mp_clr #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .NUM_RD(NR),
    .WRITE_FIRST(1), .CLR_ON_RST(0)
  ) dut_b (
    .clk(clk), .rst(rst), .clr_i(b_clr), .busy_o(b_busy), .we_i(b_we), .be_i(b_be),
    .waddr_i(b_waddr), .wdata_i(b_wdata), .re_i(b_re), .raddr_i(b_raddr),
    .rdata_o(b_rdata), .rvalid_o(b_rvalid)
  );

  always #5 clk = ~clk;

  // One clock of DUT a: drive, push expectations from the model, capture outputs.
  task automatic cycle(input logic exp_busy, input logic c, input logic w,
                       input logic [3:0] b, input logic [3:0] wa, input logic [35:0] wd,
                       input logic [1:0] r, input logic [3:0] ra0, input logic [3:0] ra1);
    logic [3:0] ra [NR];
    sb_entry_t  e;
    ra[0] = ra0;
    ra[1] = ra1;
    clr = c; we = w; be = b; waddr = wa; wdata = wd; re = r; raddr = {ra1, ra0};
    e.tag = "busy"; e.val = {35'd0, exp_busy};  exp_q.push_back(e);
    e.tag = "busy"; e.val = {35'd0, busy};      obs_q.push_back(e);
    for (int k = 0; k < NR; k++) begin
      if (!exp_busy && r[k]) last_rd[k] = model_mem[ra[k]];
      e.tag = $sformatf("rvalid%0d", k); e.val = {35'd0, (!exp_busy && r[k])}; exp_q.push_back(e);
      e.tag = $sformatf("rdata%0d", k);  e.val = last_rd[k];                    exp_q.push_back(e);
    end
    if (!exp_busy) begin
      if (w) begin
        for (int i = 0; i < NBL; i++) begin
          if (b[i]) model_mem[wa][i*BW +: BW] = wd[i*BW +: BW];
        end
      end
      if (c) begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) begin
      e.tag = $sformatf("rvalid%0d", k); e.val = {35'd0, rvalid[k]};      obs_q.push_back(e);
      e.tag = $sformatf("rdata%0d", k);  e.val = rdata[k*DW +: DW];       obs_q.push_back(e);
    end
    clr = 0; we = 0; be = '0; re = '0;
  endtask

  task automatic test_reset();
    sb_entry_t e, o;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset busy_a: got %b expected 1", busy); end
    tests_run++;
    if (rvalid !== 2'b00 || rdata !== '0) begin
      tests_failed++; $display("[TB] FAIL reset outputs_a: got rvalid=%b rdata=%h expected 0", rvalid, rdata);
    end
    tests_run++;
    if (b_busy !== 1'b0 || b_rvalid !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL reset outputs_b: got busy=%b rvalid=%b expected 0", b_busy, b_rvalid);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
    tests_run++;
    if (n != 16) begin tests_failed++; $display("[TB] FAIL reset sweep_len: got %0d expected 16", n); end
    tests_run++;
    if (b_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy_b: got %b expected 0", b_busy); end
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    for (int k = 0; k < NR; k++) last_rd[k] = '0;
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 4'h0, 4'h0, 36'h0, 2'b11, 4'(i), 4'(15 - i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o.val !== e.val) begin tests_failed++; $display("[TB] FAIL reset %s: got %h expected %h", e.tag, o.val, e.val); end
    end
  endtask

  task automatic test_byte_enables();
    sb_entry_t e, o;
    cycle(0, 0, 1, 4'hF,    4'd3, 36'hF_FFFF_FFFF, 2'b00, 4'd0, 4'd0);
    cycle(0, 0, 1, 4'b0010, 4'd3, 36'h0,           2'b00, 4'd0, 4'd0);
    cycle(0, 0, 0, 4'h0,    4'd0, 36'h0,           2'b01, 4'd3, 4'd0);
    cycle(0, 0, 1, 4'h0,    4'd3, 36'h0,           2'b10, 4'd0, 4'd3);
    cycle(0, 0, 0, 4'h0,    4'd0, 36'h0,           2'b11, 4'd3, 4'd3);
    tests_run++;
    if (rdata[35:0] !== 36'hF_FFFC_01FF) begin
      tests_failed++; $display("[TB] FAIL byte_en lane_merge: got %h expected fffc01ff", rdata[35:0]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o.val !== e.val) begin tests_failed++; $display("[TB] FAIL byte_en %s: got %h expected %h", e.tag, o.val, e.val); end
    end
  endtask

  task automatic test_collision();
    sb_entry_t e, o;
    cycle(0, 0, 1, 4'hF, 4'd5, 36'h1_2345_6789, 2'b00, 4'd0, 4'd0);
    cycle(0, 0, 1, 4'hF, 4'd5, 36'h0_AAAA_AAAA, 2'b11, 4'd5, 4'd5);
    tests_run++;
    if (rdata[35:0] !== 36'h1_2345_6789) begin
      tests_failed++; $display("[TB] FAIL collision read_first: got %h expected 123456789", rdata[35:0]);
    end
    cycle(0, 0, 0, 4'h0, 4'd0, 36'h0, 2'b01, 4'd5, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o.val !== e.val) begin tests_failed++; $display("[TB] FAIL collision %s: got %h expected %h", e.tag, o.val, e.val); end
    end
  endtask

  task automatic test_dual_read();
    sb_entry_t e, o;
    cycle(0, 0, 1, 4'hF, 4'd1, 36'h0_1357_9BDF, 2'b00, 4'd0, 4'd0);
    cycle(0, 0, 1, 4'hF, 4'd2, 36'h0_2468_ACE0, 2'b00, 4'd0, 4'd0);
    cycle(0, 0, 0, 4'h0, 4'd0, 36'h0,           2'b11, 4'd1, 4'd2);
    cycle(0, 0, 0, 4'h0, 4'd0, 36'h0,           2'b00, 4'd9, 4'd9);
    cycle(0, 0, 0, 4'h0, 4'd0, 36'h0,           2'b10, 4'd0, 4'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o.val !== e.val) begin tests_failed++; $display("[TB] FAIL dual_read %s: got %h expected %h", e.tag, o.val, e.val); end
    end
  endtask

  task automatic test_clear_request();
    sb_entry_t e, o;
    cycle(0, 0, 1, 4'hF, 4'd7, 36'h0_7777_7777, 2'b00, 4'd0, 4'd0);
    cycle(0, 1, 0, 4'h0, 4'd0, 36'h0,           2'b00, 4'd0, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1, (i == 10), 1, 4'hF, 4'd7, 36'h0_DEAD_BEEF, 2'b11, 4'd7, 4'd7);
    end
    cycle(0, 0, 0, 4'h0, 4'd0, 36'h0, 2'b11, 4'd7, 4'd7);
    cycle(0, 0, 0, 4'h0, 4'd0, 36'h0, 2'b00, 4'd0, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o.val !== e.val) begin tests_failed++; $display("[TB] FAIL clear_req %s: got %h expected %h", e.tag, o.val, e.val); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    sb_entry_t e, o;
    int n;
    cycle(0, 0, 1, 4'hF, 4'd12, 36'h1_0101_0101, 2'b00, 4'd0, 4'd0);
    cycle(0, 0, 1, 4'hF, 4'd2,  36'h0_5A5A_5A5A, 2'b00, 4'd0, 4'd0);
    cycle(0, 1, 0, 4'h0, 4'd0,  36'h0,           2'b00, 4'd0, 4'd0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 4'h0, 4'd0, 36'h0, 2'b00, 4'd0, 4'd0);
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b1 || rvalid !== 2'b00 || rdata !== '0) begin
      tests_failed++; $display("[TB] FAIL mid_reset outputs: got busy=%b rvalid=%b rdata=%h expected 1/0/0", busy, rvalid, rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(posedge clk); #1; end
    tests_run++;
    if (n != 16) begin tests_failed++; $display("[TB] FAIL mid_reset sweep_len: got %0d expected 16", n); end
    for (int k = 0; k < NR; k++) last_rd[k] = '0;
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 4'h0, 4'h0, 36'h0, 2'b11, 4'(i), 4'(i));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
      if (o.val !== e.val) begin tests_failed++; $display("[TB] FAIL mid_reset %s: got %h expected %h", e.tag, o.val, e.val); end
    end
  endtask

  task automatic test_write_first();
    b_we = 1; b_be = 4'hF; b_waddr = 4'd5; b_wdata = 36'h1_2345_6789; b_re = 2'b00;
    @(posedge clk); #1;
    b_we = 1; b_be = 4'hF; b_waddr = 4'd5; b_wdata = 36'h0_AAAA_AAAA; b_re = 2'b11; b_raddr = {4'd5, 4'd5};
    @(posedge clk); #1;
    tests_run++;
    if (b_rvalid !== 2'b11) begin tests_failed++; $display("[TB] FAIL write_first rvalid: got %b expected 11", b_rvalid); end
    tests_run++;
    if (b_rdata !== {36'h0_AAAA_AAAA, 36'h0_AAAA_AAAA}) begin
      tests_failed++; $display("[TB] FAIL write_first full_word: got %h expected both 0aaaaaaaa", b_rdata);
    end
    b_we = 1; b_be = 4'b0001; b_wdata = 36'h0_0000_0055; b_re = 2'b10;
    @(posedge clk); #1;
    tests_run++;
    if (b_rvalid !== 2'b10 || b_rdata !== {36'h0_AAAA_AA55, 36'h0_AAAA_AAAA}) begin
      tests_failed++; $display("[TB] FAIL write_first partial: got rvalid=%b rdata=%h expected 10 0aaaaaa55_0aaaaaaaa", b_rvalid, b_rdata);
    end
    b_we = 0; b_be = '0; b_re = 2'b01;
    @(posedge clk); #1;
    tests_run++;
    if (b_rvalid !== 2'b01 || b_rdata[35:0] !== 36'h0_AAAA_AA55) begin
      tests_failed++; $display("[TB] FAIL write_first reread: got rvalid=%b rdata=%h expected 01 0aaaaaa55", b_rvalid, b_rdata[35:0]);
    end
    b_re = 2'b00;
  endtask

  initial begin
    clr = 0; we = 0; be = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    b_clr = 0; b_we = 0; b_be = '0; b_waddr = '0; b_wdata = '0; b_re = '0; b_raddr = '0;
    for (int k = 0; k < NR; k++) last_rd[k] = '0;
    #2;
    test_reset();
    test_byte_enables();
    test_collision();
    test_dual_read();
    test_clear_request();
    test_reset_mid_sweep();
    test_write_first();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] timeout");
  end

endmodule
